// File: rtl/lsu_mem_stage_pkg.sv
// LSU memory stage: shared encodings.
// funct3 codes, FSM states, error codes, timeout default.
package lsu_mem_stage_pkg;

    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_MIS = 2'b01,
        ERR_TMO = 2'b10
    } err_e;

    // sz is funct3[1:0]: 00 byte, 01 half, else word
    function automatic logic misaligned(
        input logic [1:0] sz,
        input logic [1:0] a
    );
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// LSU memory stage: data memory bus.
// master = LSU (req/we/addr/wdata/wstrb out), slave = memory (gnt/rvalid/rdata out).
interface lsu_mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// LSU lane logic: store strobe/replication and load extract/extend.
// in: funct3, addr_lo, wdata, rdata; out: wstrb, wdata_rep, ldata.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata
);

    logic [31:0] sh;

    always_comb begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb     = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // bring the addressed lane down to bit 0
    assign sh = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_B:    ldata = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ldata = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   ldata = {24'd0, sh[7:0]};
            F3_HU:   ldata = {16'd0, sh[15:0]};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: one load/store at a time, with timeout abort.
// in: CLK, RST, in_* request; mem: bus master; out: in_ready, wb_*, err.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_load,
    input  logic                   in_store,
    input  logic [2:0]             in_funct3,
    input  logic [31:0]            in_addr,
    input  logic [31:0]            in_wdata,
    input  logic [4:0]             in_rd,
    lsu_mem_stage_if.master        mem,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_data,
    output logic [1:0]             err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    state_e      st_q, st_d;
    err_e        err_q, err_d;
    logic [7:0]  cnt_q;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [4:0]  rd_q, wb_rd_q;
    logic [3:0]  strb;
    logic [31:0] wrep, ldata;
    logic        op, mis, tmo, we;

    assign op  = in_valid & (in_load | in_store);
    assign mis = misaligned(in_funct3[1:0], in_addr[1:0]);
    assign tmo = (cnt_q + 8'd1) == TMO;

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .wstrb     (strb),
        .wdata_rep (wrep),
        .ldata     (ldata)
    );

    // err only changes on entry to RESP so it holds elsewhere
    always_comb begin
        st_d  = st_q;
        err_d = err_q;
        unique case (st_q)
            S_IDLE: begin
                if (op) begin
                    if (mis) begin
                        st_d  = S_RESP;
                        err_d = ERR_MIS;
                    end else begin
                        st_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // grant beats a simultaneous timeout
                if (mem.mem_gnt) begin
                    if (ld_q) begin
                        st_d = S_WAIT_R;
                    end else begin
                        st_d  = S_RESP;
                        err_d = ERR_OK;
                    end
                end else if (tmo) begin
                    st_d  = S_RESP;
                    err_d = ERR_TMO;
                end
            end
            S_WAIT_R: begin
                if (mem.mem_rvalid) begin
                    st_d  = S_RESP;
                    err_d = ERR_OK;
                end else if (tmo) begin
                    st_d  = S_RESP;
                    err_d = ERR_TMO;
                end
            end
            S_RESP:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q      <= S_IDLE;
            err_q     <= ERR_OK;
            cnt_q     <= 8'd0;
            ld_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rd_q      <= 5'd0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            st_q  <= st_d;
            err_q <= err_d;
            if (st_d != st_q) begin
                cnt_q <= 8'd0;
            end else if (st_q == S_REQ || st_q == S_WAIT_R) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (st_q == S_IDLE && op) begin
                ld_q    <= in_load;
                f3_q    <= in_funct3;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                rd_q    <= in_rd;
            end
            if (st_d == S_RESP && st_q != S_RESP) begin
                wb_rd_q <= (st_q == S_IDLE) ? in_rd : rd_q;
            end
            if (st_q == S_WAIT_R && mem.mem_rvalid) begin
                wb_data_q <= ldata;
            end
        end
    end

    assign we             = (st_q == S_REQ) & ~ld_q;
    assign in_ready       = st_q == S_IDLE;
    assign mem.mem_req    = st_q == S_REQ;
    assign mem.mem_we     = we;
    assign mem.mem_addr   = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata  = wrep;
    assign mem.mem_wstrb  = we ? strb : 4'b0000;
    assign wb_valid       = st_q == S_RESP;
    assign wb_we          = (st_q == S_RESP) & ld_q & (err_q == ERR_OK);
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign err            = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// LSU memory stage bench: directed transactions, timeline model,
// per-cycle compare plus literal pins.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, in_load, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  err;

    lsu_mem_stage_if mem ();

    lsu_mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_load   (in_load),
        .in_store  (in_store),
        .in_funct3 (in_funct3),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .mem       (mem),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic        e_ready, e_req, e_we, e_wbv, e_wbwe;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_strb;
    logic [4:0]  e_rd;
    logic [1:0]  e_err;
    logic [31:0] h_data;
    logic [4:0]  h_rd;
    logic [1:0]  h_err;

    int          req_cnt, wbv_cnt;
    logic [31:0] c_addr, c_wdata, c_data;
    logic [3:0]  c_strb;
    logic        c_wbwe;
    logic [1:0]  c_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_strb(input logic [2:0] f,
                                          input logic [31:0] a);
        if (f[1:0] == 2'b00) return 4'(1 << (a % 4));
        if (f[1:0] == 2'b01) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f,
                                            input logic [31:0] d);
        if (f[1:0] == 2'b00) return (d % 256) * 32'h0101_0101;
        if (f[1:0] == 2'b01) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit m_mis(input logic [2:0] f,
                                 input logic [31:0] a);
        if (f[1:0] == 2'b00) return 1'b0;
        if (f[1:0] == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * (a % 4));
        case (f)
            F3_B: begin
                v = v % 256;
                if (v >= 128) v = v - 256;
            end
            F3_H: begin
                v = v % 65536;
                if (v >= 32768) v = v - 65536;
            end
            F3_BU:   v = v % 256;
            F3_HU:   v = v % 65536;
            default: v = r;
        endcase
        return v;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("in_ready", in_ready, e_ready);
            chk("mem_req", mem.mem_req, e_req);
            if (e_req) begin
                chk("mem_we", mem.mem_we, e_we);
                chk("mem_addr", mem.mem_addr, e_addr);
                if (e_we) begin
                    chk("mem_wdata", mem.mem_wdata, e_wdata);
                    chk("mem_wstrb", mem.mem_wstrb, e_strb);
                end
            end
            chk("wb_valid", wb_valid, e_wbv);
            chk("wb_we", wb_we, e_wbwe);
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_data", wb_data, e_data);
            chk("err", err, e_err);
        end
    end

    always @(negedge CLK) begin
        if (mem.mem_req === 1'b1) begin
            req_cnt++;
            c_addr  = mem.mem_addr;
            c_wdata = mem.mem_wdata;
            c_strb  = mem.mem_wstrb;
        end
        if (wb_valid === 1'b1) begin
            wbv_cnt++;
            c_data = wb_data;
            c_wbwe = wb_we;
            c_err  = err;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1'b1;
        e_req   = 1'b0;
        e_we    = 1'b0;
        e_wbv   = 1'b0;
        e_wbwe  = 1'b0;
        e_rd    = h_rd;
        e_data  = h_data;
        e_err   = h_err;
    endtask

    // g: REQ cycle carrying mem_gnt (0 = never)
    // rv: WAIT_R cycle carrying mem_rvalid (0 = never)
    task automatic txn(input bit ld, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input int g, input int rv,
                       input logic [31:0] rdata);
        bit         ok;
        int         nreq;
        int         nw;
        logic [1:0] ex;
        ok      = 1'b1;
        ex      = 2'b00;
        req_cnt = 0;
        wbv_cnt = 0;
        in_valid  = 1'b1;
        in_load   = ld;
        in_store  = !ld;
        in_funct3 = f;
        in_addr   = a;
        in_wdata  = d;
        in_rd     = rd;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = $urandom;
        set_idle();
        step();
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_store  = 1'b0;
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_rd     = 5'($urandom);
        mem.mem_rvalid = 1'b0;
        if (m_mis(f, a)) begin
            ok = 1'b0;
            ex = 2'b01;
        end else begin
            nreq = (g >= 1 && g <= TO) ? g : TO;
            for (int k = 1; k <= nreq; k++) begin
                e_ready = 1'b0;
                e_req   = 1'b1;
                e_we    = !ld;
                e_addr  = a - (a % 4);
                e_wdata = m_wdata(f, d);
                e_strb  = m_strb(f, a);
                mem.mem_gnt    = (k == g);
                mem.mem_rvalid = ld;
                mem.mem_rdata  = $urandom;
                step();
            end
            mem.mem_gnt    = 1'b0;
            mem.mem_rvalid = 1'b0;
            if (g < 1 || g > TO) begin
                ok = 1'b0;
                ex = 2'b10;
            end else if (ld) begin
                nw = (rv >= 1 && rv <= TO) ? rv : TO;
                for (int k = 1; k <= nw; k++) begin
                    e_ready = 1'b0;
                    e_req   = 1'b0;
                    mem.mem_rvalid = (k == rv);
                    mem.mem_rdata  = (k == rv) ? rdata : $urandom;
                    step();
                end
                mem.mem_rvalid = 1'b0;
                if (rv < 1 || rv > TO) begin
                    ok = 1'b0;
                    ex = 2'b10;
                end
            end
        end
        if (ld && ok) h_data = m_load(f, a, rdata);
        h_rd  = rd;
        h_err = ex;
        e_ready = 1'b0;
        e_req   = 1'b0;
        e_wbv   = 1'b1;
        e_wbwe  = ld && ok;
        e_rd    = h_rd;
        e_data  = h_data;
        e_err   = h_err;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = $urandom;
        step();
        mem.mem_rvalid = 1'b0;
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'd0;
        h_data = 32'd0; h_rd = 5'd0; h_err = 2'd0;
        req_cnt = 0; wbv_cnt = 0;
        set_idle();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_req", mem.mem_req, 0);
        chk("rst_we", mem.mem_we, 0);
        chk("rst_strb", mem.mem_wstrb, 0);
        chk("rst_addr", mem.mem_addr, 0);
        chk("rst_wdata", mem.mem_wdata, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbwe", wb_we, 0);
        chk("rst_wbrd", wb_rd, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk_en = 1'b1;

        txn(0, F3_B, 32'h1003, 32'h0000_00AB, 5'd1, 2, 0, 0);
        chk("sb_addr", c_addr, 32'h1000);
        chk("sb_strb", c_strb, 4'b1000);
        chk("sb_wdata", c_wdata, 32'hABAB_ABAB);
        chk("sb_pulses", wbv_cnt, 1);
        chk("sb_wbwe", c_wbwe, 0);
        chk("sb_reqcyc", req_cnt, 2);

        txn(1, F3_B, 32'h2001, 32'd0, 5'd5, 1, 2, 32'h0000_8000);
        chk("lb_data", c_data, 32'hFFFF_FF80);
        chk("lb_wbwe", c_wbwe, 1);
        txn(1, F3_BU, 32'h2001, 32'd0, 5'd6, 1, 1, 32'h0000_8000);
        chk("lbu_data", c_data, 32'h0000_0080);

        txn(1, F3_W, 32'h3002, 32'd0, 5'd7, 1, 1, 32'd0);
        chk("mis_reqcyc", req_cnt, 0);
        chk("mis_err", c_err, 2'b01);
        chk("mis_pulses", wbv_cnt, 1);

        txn(1, F3_W, 32'h4000, 32'd0, 5'd8, 0, 0, 32'd0);
        chk("tmo_reqcyc", req_cnt, 4);
        chk("tmo_err", c_err, 2'b10);
        chk("tmo_wbwe", c_wbwe, 0);

        txn(0, F3_H, 32'h5002, 32'h1234_BEEF, 5'd9, 1, 0, 0);
        chk("sh_strb", c_strb, 4'b1100);
        chk("sh_wdata", c_wdata, 32'hBEEF_BEEF);
        txn(0, F3_W, 32'h6000, 32'hCAFE_F00D, 5'd10, TO, 0, 0);
        chk("sw_gntwins", c_err, 2'b00);
        txn(0, F3_B, 32'h6001, 32'h55, 5'd11, 0, 0, 0);
        txn(1, F3_H, 32'h7002, 32'd0, 5'd12, 2, 3, 32'h8001_7FFF);
        chk("lh_data", c_data, 32'hFFFF_8001);
        txn(1, F3_HU, 32'h7000, 32'd0, 5'd13, 1, 2, 32'h1234_F00D);
        chk("lhu_data", c_data, 32'h0000_F00D);
        txn(1, F3_H, 32'h9001, 32'd0, 5'd14, 1, 1, 32'd0);
        txn(0, F3_H, 32'h9003, 32'h77, 5'd15, 1, 0, 0);
        txn(1, F3_W, 32'hA004, 32'd0, 5'd16, 3, 0, 32'd0);
        chk("rtmo_err", c_err, 2'b10);

        in_valid = 1'b1;
        in_load  = 1'b0;
        in_store = 1'b0;
        req_cnt  = 0;
        repeat (3) step();
        in_valid = 1'b0;
        chk("noop_reqcyc", req_cnt, 0);

        chk_en   = 1'b0;
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        in_funct3 = F3_W; in_addr = 32'hB000; in_rd = 5'd20;
        step();
        in_valid = 1'b0; in_load = 1'b0;
        mem.mem_gnt = 1'b1;
        step();
        mem.mem_gnt = 1'b0;
        step();
        wbv_cnt = 0;
        #2;
        RST = 1'b1;
        #1;
        chk("ar_ready", in_ready, 1);
        chk("ar_req", mem.mem_req, 0);
        chk("ar_addr", mem.mem_addr, 0);
        chk("ar_wbv", wb_valid, 0);
        chk("ar_wbrd", wb_rd, 0);
        chk("ar_wbdata", wb_data, 0);
        chk("ar_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = 32'h5555_5555;
        step();
        mem.mem_rvalid = 1'b0;
        h_data = 32'd0; h_rd = 5'd0; h_err = 2'd0;
        set_idle();
        chk_en = 1'b1;
        repeat (3) step();
        chk("ar_nowb", wbv_cnt, 0);

        txn(1, F3_W, 32'h8004, 32'd0, 5'd21, 1, 3, 32'hDEAD_BEEF);
        chk("lw_data", c_data, 32'hDEAD_BEEF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
